bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits between the 16-bit counter/adder result and the `hexto7seg` digit drivers. It replaces the combinational converter loop with a small FSM that has a start/busy/done handshake. The registered BCD result holds stable for the display stage until the next conversion completes.

---
 rtl/bin2bcd_seq.sv | 138 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Leading-zero blanking is generated only when `BIN2BCD_SEQ_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                Clk,
  input  logic                Clrn,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   blank
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BW    = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             done_q, done_d;

  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    shifted;
  logic             load_result;

  // Add-3 correction on every digit that would overflow past 9 after doubling.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] dig;
      assign dig = scratch_q[4*gi +: 4];
      assign adjusted[4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end
  endgenerate

  assign shifted     = {adjusted[BW-2:0], shift_q[WIDTH-1]};
  assign load_result = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (load_result) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef BIN2BCD_SEQ_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // upper_zero[k]: digit k and every digit above it in the new result are zero.
  logic [DIGITS:1]    upper_zero;
  logic [DIGITS-1:0]  blank_calc;
  logic [DIGITS-1:0]  blank_q, blank_d;

  assign upper_zero[DIGITS] = (shifted[4*(DIGITS-1) +: 4] == 4'd0);
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign upper_zero[gi] = ((gi == DIGITS - 1) ? 1'b1 : upper_zero[gi+1])
                              & (shifted[4*gi +: 4] == 4'd0);
    end
  endgenerate

  assign blank_calc = {upper_zero[DIGITS-1:1], 1'b0};

  always_comb begin
    blank_d = blank_q;
    if (load_result) begin
      blank_d = blank_calc;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq; expected results come from
// decimal arithmetic on the accepted input, compared whenever the DUT pulses done.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;
`ifdef BIN2BCD_SEQ_BLANK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic              Clk   = 1'b0;
  logic              Clrn  = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  bin   = '0;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bcd;
  logic [DIGITS-1:0] blank;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [WIDTH-1:0]  val;
    logic [BW-1:0]     bcd;
    logic [DIGITS-1:0] blank;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  exp_t mon_e;
  int   cycles_left = 0;
  bit   model_done  = 1'b0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DIGITS-1:0] reset_blank();
    logic [DIGITS-1:0] r;
    r = '0;
    if (EN) begin
      for (int k = 1; k < DIGITS; k++) r[k] = 1'b1;
    end
    return r;
  endfunction

  // Reference: decimal digits by division; blank[k] set when value < 10^k.
  function automatic exp_t make_exp(input int unsigned v);
    exp_t e;
    longint unsigned p;
    e.val   = WIDTH'(v);
    e.bcd   = '0;
    e.blank = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      e.bcd[4*k +: 4] = 4'((v / p) % 10);
      if (EN && k >= 1) e.blank[k] = (v < p);
      p = p * 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: a request is accepted only when no conversion is outstanding;
  // its result is due WIDTH edges later.
  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      cycles_left = 0;
      model_done  = 1'b0;
      exp_q.delete();
      held.val   = '0;
      held.bcd   = '0;
      held.blank = reset_blank();
    end else begin
      model_done = 1'b0;
      if (cycles_left > 0) begin
        cycles_left--;
        if (cycles_left == 0) model_done = 1'b1;
      end else if (start) begin
        exp_q.push_back(make_exp(32'(bin)));
        cycles_left = WIDTH;
      end
    end
  end

  // Monitor
  always @(negedge Clk) begin
    if (Clrn) begin
      chk("busy", 32'(busy), 32'(cycles_left > 0));
      chk("done", 32'(done), 32'(model_done));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_request", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          held  = mon_e;
          chk("bcd", 32'(bcd), 32'(mon_e.bcd));
          chk("blank", 32'(blank), 32'(mon_e.blank));
          $display("conv bin=%0d bcd=%05h blank=%b", mon_e.val, bcd, blank);
        end
      end else begin
        chk("bcd_hold", 32'(bcd), 32'(held.bcd));
        chk("blank_hold", 32'(blank), 32'(held.blank));
      end
    end
  end

  // Called at a negedge: pulse start, then verify busy length, result and done width.
  task automatic conv_chk(input logic [WIDTH-1:0] v, input logic [BW-1:0] eb,
                          input logic [DIGITS-1:0] ebl);
    int n  = 0;
    int nb = 0;
    start = 1'b1;
    bin   = v;
    do begin
      @(negedge Clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
    end while (!done && n < 40);
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_cycles", 32'(nb), 32'(WIDTH));
    chk("direct_bcd", 32'(bcd), 32'(eb));
    chk("direct_blank", 32'(blank), 32'(EN ? ebl : '0));
    @(negedge Clk);
    chk("done_width", 32'(done), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cycles_left != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_blank", 32'(blank), 32'(reset_blank()));
    @(negedge Clk);
    Clrn = 1'b1;

    conv_chk(16'd0,     20'h00000, 5'b11110);
    conv_chk(16'd65535, 20'h65535, 5'b00000);
    conv_chk(16'd1234,  20'h01234, 5'b10000);

    // Second request during busy must be ignored
    start = 1'b1; bin = 16'd99;
    @(negedge Clk); start = 1'b0; bin = 16'd0;
    repeat (3) @(negedge Clk);
    start = 1'b1; bin = 16'd500;
    @(negedge Clk); start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge Clk); n++; end
    chk("ignored_done", 32'(done), 32'd1);
    chk("ignored_bcd", 32'(bcd), 32'h00099);
    chk("ignored_blank", 32'(blank), 32'(EN ? 5'b11100 : 5'b00000));
    @(negedge Clk);

    // start held high: back-to-back conversions
    start = 1'b1;
    repeat (5 * (WIDTH + 1) + 2) begin
      bin = WIDTH'($urandom);
      @(negedge Clk);
    end
    start = 1'b0;
    wait_idle();
    @(negedge Clk);

    // Reset mid-conversion
    start = 1'b1; bin = 16'd40000;
    @(negedge Clk); start = 1'b0;
    repeat (7) @(negedge Clk);
    @(posedge Clk);
    #2 Clrn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_blank", 32'(blank), 32'(reset_blank()));
    @(negedge Clk);
    Clrn = 1'b1;
    conv_chk(16'd40000, 20'h40000, 5'b00000);

    // Randomized traffic, including requests issued while busy
    for (int i = 0; i < 1500; i++) begin
      start = 1'b1;
      if (i % 97 == 0)      bin = 16'hFFFF;
      else if (i % 89 == 0) bin = 16'h0000;
      else                  bin = WIDTH'($urandom);
      @(negedge Clk);
      start = 1'b0;
      repeat ($urandom_range(0, 20)) begin
        start = ($urandom_range(0, 4) == 0);
        bin   = WIDTH'($urandom);
        @(negedge Clk);
      end
      start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
